spi_cfg_sequencer: RTL and testbench

- Upstream feeder for the SPI config transmitter. It walks a fixed table of register address/data pairs and presents each pair on cfg_addr/cfg_data.
- For each entry it raises en_config and waits for the transmitter busy handshake to complete before moving on.
- It enforces a programmable inter-frame gap and reports done when the last entry has been sent, or error on handshake timeout.
- It sits between the power-up/control logic and the SPI transmitter. Its outputs drive that transmitter's en_config, Config_reg_A and Config_reg_data inputs directly.

---
 rtl/spi_cfg_pkg.sv | 26 ++
 rtl/spi_cfg_rom.sv | 30 +++
 rtl/spi_cfg_sequencer.sv | 153 +++++++++++++++
 tb/tb_spi_cfg_sequencer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_cfg_pkg.sv
// Shared definitions for the SPI configuration sequencer and its register table.
// Holds the state encoding, the address/data widths and the transmitter frame
// constants, so the sequencer and the transmitter agree on the frame layout.
package spi_cfg_pkg;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    XFER = 3'd2,
    GAP  = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } seq_state_t;

  // Instruction word: R/W bit (0 = write), W1:W0 = 00 (single byte), then A12..A0.
  localparam logic       FRAME_RW_WRITE = 1'b0;
  localparam logic [1:0] FRAME_W_1BYTE  = 2'b00;

  function automatic logic [15:0] frame_instr(input logic [ADDR_W-1:0] addr);
    return {FRAME_RW_WRITE, FRAME_W_1BYTE, addr};
  endfunction

endpackage

// File: rtl/spi_cfg_rom.sv
// Board register table: maps a table index to a {address, data} pair.
// Kept in its own module so a different board can swap in its own table.
module spi_cfg_rom
  import spi_cfg_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic [IDX_W-1:0]  idx,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  // Purely combinational lookup; the sequencer registers the result.
  always_comb begin
    addr = '0;
    data = '0;
    case (32'(idx))
      32'd0:   begin addr = 13'h000; data = 8'h18; end
      32'd1:   begin addr = 13'h005; data = 8'h01; end
      32'd2:   begin addr = 13'h0FF; data = 8'h01; end
      32'd3:   begin addr = 13'h014; data = 8'h00; end
      32'd4:   begin addr = 13'h016; data = 8'h02; end
      32'd5:   begin addr = 13'h018; data = 8'h0F; end
      32'd6:   begin addr = 13'h0FF; data = 8'h01; end
      32'd7:   begin addr = 13'h00F; data = 8'h00; end
      default: begin addr = '0;      data = '0;    end
    endcase
  end

endmodule

// File: rtl/spi_cfg_sequencer.sv
// Walks the register table and hands each address/data pair to the SPI
// configuration transmitter using the en_config / tx_busy handshake, with a
// programmable idle gap between frames.
// Optional handshake timeout: define SPI_CFG_SEQ_TIMEOUT_EN to enable the
// REQ/XFER watchdog and the ERR state; otherwise error is tied low.
module spi_cfg_sequencer
  import spi_cfg_pkg::*;
#(
  parameter int NUM_REGS       = 8,
  parameter int IDX_W          = 4,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             tx_busy,
  output logic             en_config,
  output logic [12:0]      cfg_addr,
  output logic [7:0]       cfg_data,
  output logic [IDX_W-1:0] reg_index,
  output logic             seq_busy,
  output logic             done,
  output logic             error
);

  localparam int               GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'((NUM_REGS > 0) ? NUM_REGS - 1 : 0);
  localparam logic             ZERO_REGS = (NUM_REGS == 0);
  localparam logic             NO_GAP    = (GAP_CYCLES == 0);

  // Reject parameter sets the index or watchdog cannot represent.
  if (TIMEOUT_CYCLES < 1 || NUM_REGS > (1 << IDX_W)) begin : g_param_check
    $error("spi_cfg_sequencer: illegal parameter combination");
  end

  seq_state_t        state, state_n;
  logic [IDX_W-1:0]  idx_n;
  logic [GAP_W-1:0]  gap_cnt, gap_cnt_n;
  logic [12:0]       rom_addr;
  logic [7:0]        rom_data;

`ifdef SPI_CFG_SEQ_TIMEOUT_EN
  localparam int              TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] to_cnt, to_cnt_n;
`endif

  // The table is looked up with the upcoming index so the pair is registered
  // in the same edge that raises en_config.
  spi_cfg_rom #(.IDX_W(IDX_W)) u_rom (
    .idx  (idx_n),
    .addr (rom_addr),
    .data (rom_data)
  );

  // Next-state, next-index and counter logic for the handshake walk.
  always_comb begin
    state_n   = state;
    idx_n     = reg_index;
    gap_cnt_n = gap_cnt;
    case (state)
      IDLE, DONE: begin
        if (start && !tx_busy) begin
          idx_n   = '0;
          state_n = ZERO_REGS ? DONE : REQ;
        end
      end
      REQ: begin
        if (tx_busy) state_n = XFER;
      end
      XFER: begin
        if (!tx_busy) begin
          if (reg_index == LAST_IDX) begin
            state_n = DONE;
          end else begin
            idx_n     = reg_index + 1'b1;
            gap_cnt_n = '0;
            state_n   = NO_GAP ? REQ : GAP;
          end
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          if (!tx_busy) state_n = REQ;
        end else begin
          gap_cnt_n = gap_cnt + 1'b1;
        end
      end
`ifdef SPI_CFG_SEQ_TIMEOUT_EN
      ERR: begin
        if (start) begin
          idx_n   = '0;
          state_n = ZERO_REGS ? DONE : REQ;
        end
      end
`endif
      default: state_n = IDLE;
    endcase
`ifdef SPI_CFG_SEQ_TIMEOUT_EN
    to_cnt_n = '0;
    if ((state == REQ || state == XFER) && state_n == state) begin
      if (to_cnt == TO_LAST) begin
        state_n = ERR;
      end else begin
        to_cnt_n = to_cnt + 1'b1;
      end
    end
`endif
  end

  // State register plus registered outputs derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      reg_index <= '0;
      gap_cnt   <= '0;
      en_config <= 1'b0;
      seq_busy  <= 1'b0;
      done      <= 1'b0;
      cfg_addr  <= '0;
      cfg_data  <= '0;
    end else begin
      state     <= state_n;
      reg_index <= idx_n;
      gap_cnt   <= gap_cnt_n;
      en_config <= (state_n == REQ);
      seq_busy  <= (state_n inside {REQ, XFER, GAP});
      done      <= (state_n == DONE);
      if (state_n == REQ && state != REQ) begin
        cfg_addr <= rom_addr;
        cfg_data <= rom_data;
      end
    end
  end

`ifdef SPI_CFG_SEQ_TIMEOUT_EN
  // Watchdog counter and sticky error flag for a stalled handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
      error  <= 1'b0;
    end else begin
      to_cnt <= to_cnt_n;
      error  <= (state_n == ERR);
    end
  end
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_spi_cfg_sequencer.sv
// Self-checking bench for spi_cfg_sequencer. Three instances share clock,
// reset and tx_busy: a 3-entry table with a 4-cycle gap, an empty table, and
// a 3-entry table with no gap. The bench plays the transmitter with random
// response delays and frame lengths and predicts every cycle from a schedule
// computed arithmetically from those random choices.
module tb_spi_cfg_sequencer;

  logic clk = 1'b0;
  logic rst, tx_busy, start_m, start_z, start_g;

  logic        en_m, sb_m, done_m, err_m;
  logic [12:0] addr_m;
  logic [7:0]  data_m;
  logic [3:0]  idx_m;
  logic        en_z, sb_z, done_z, err_z;
  logic [12:0] addr_z;
  logic [7:0]  data_z;
  logic [3:0]  idx_z;
  logic        en_g, sb_g, done_g, err_g;
  logic [12:0] addr_g;
  logic [7:0]  data_g;
  logic [3:0]  idx_g;

  int assertions = 0;
  int failures   = 0;
  int sel        = 0;

  logic        o_en, o_sb, o_done, o_err;
  logic [12:0] o_addr;
  logic [7:0]  o_data;
  logic [3:0]  o_idx;

  logic [12:0] tblAddr [3] = '{13'h000, 13'h005, 13'h0FF};
  logic [7:0]  tblData [3] = '{8'h18, 8'h01, 8'h01};

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  spi_cfg_sequencer #(.NUM_REGS(3), .IDX_W(4), .GAP_CYCLES(4), .TIMEOUT_CYCLES(20)) dut_m (
    .clk(clk), .rst(rst), .start(start_m), .tx_busy(tx_busy), .en_config(en_m),
    .cfg_addr(addr_m), .cfg_data(data_m), .reg_index(idx_m), .seq_busy(sb_m),
    .done(done_m), .error(err_m));

  spi_cfg_sequencer #(.NUM_REGS(0), .IDX_W(4), .GAP_CYCLES(4), .TIMEOUT_CYCLES(20)) dut_z (
    .clk(clk), .rst(rst), .start(start_z), .tx_busy(tx_busy), .en_config(en_z),
    .cfg_addr(addr_z), .cfg_data(data_z), .reg_index(idx_z), .seq_busy(sb_z),
    .done(done_z), .error(err_z));

  spi_cfg_sequencer #(.NUM_REGS(3), .IDX_W(4), .GAP_CYCLES(0), .TIMEOUT_CYCLES(20)) dut_g (
    .clk(clk), .rst(rst), .start(start_g), .tx_busy(tx_busy), .en_config(en_g),
    .cfg_addr(addr_g), .cfg_data(data_g), .reg_index(idx_g), .seq_busy(sb_g),
    .done(done_g), .error(err_g));

  // Route the selected instance's outputs to the common observation signals.
  always_comb begin
    {o_en, o_sb, o_done, o_err, o_idx, o_addr, o_data} =
      {en_m, sb_m, done_m, err_m, idx_m, addr_m, data_m};
    case (sel)
      1: {o_en, o_sb, o_done, o_err, o_idx, o_addr, o_data} =
           {en_z, sb_z, done_z, err_z, idx_z, addr_z, data_z};
      2: {o_en, o_sb, o_done, o_err, o_idx, o_addr, o_data} =
           {en_g, sb_g, done_g, err_g, idx_g, addr_g, data_g};
      default: ;
    endcase
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertions++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput(tag, 32'({o_en, o_sb, o_done, o_err, o_idx, o_addr, o_data}), 32'd0);
  endtask

  // Drive inputs for the next edge, then advance to 1 unit after that edge.
  task automatic applyStimulus(input logic busyV, input logic startV, input logic rstV);
    tx_busy = busyV;
    rst     = rstV;
    start_m = (sel == 0) ? startV : 1'b0;
    start_z = (sel == 1) ? startV : 1'b0;
    start_g = (sel == 2) ? startV : 1'b0;
    @(posedge clk);
    #1;
  endtask

  // One full 3-entry sequence on the selected instance. Sample s is the
  // value seen 1 unit after edge s; start is sampled on edge 0.
  // For entry k the transmitter raises busy d cycles after seeing the
  // request and holds it L cycles, so en_config drops at R+d+1, the entry
  // completes at R+d+L+1 and the next request follows gap cycles later.
  task automatic runSequence(input int gap, input bit doAbort);
    int R[3], B[3], F1[3], d[3], L[3];
    int t, last, abortAt, expIdx, kEn, kCfg;
    bit glitch, aborted;
    logic busyV, expEn;
    t = 0;
    for (int k = 0; k < 3; k++) begin
      d[k]  = $urandom_range(1, 3);
      L[k]  = $urandom_range(1, 5);
      R[k]  = t;
      B[k]  = R[k] + d[k] + 1;
      F1[k] = R[k] + d[k] + L[k] + 1;
      t     = F1[k] + gap;
    end
    last    = F1[2];
    abortAt = B[1];
    glitch  = ($urandom_range(0, 1) == 1);
    aborted = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int s = 0; s <= last + 3; s++) begin
      if (doAbort && s == abortAt + 1) begin
        checkAllZero($sformatf("reset_zero s%0d", s));
        aborted = 1'b1;
        break;
      end
      expEn = 1'b0; kEn = -1; kCfg = -1; expIdx = 0;
      for (int k = 0; k < 3; k++) begin
        if (R[k] <= s && s < B[k])  begin expEn = 1'b1; kEn = k; end
        if (R[k] <= s && s < F1[k]) kCfg = k;
        if (k < 2 && F1[k] <= s)    expIdx++;
      end
      checkOutput($sformatf("en_config s%0d", s), 32'(o_en), 32'(expEn));
      checkOutput($sformatf("seq_busy s%0d", s), 32'(o_sb), 32'(s < last));
      checkOutput($sformatf("done s%0d", s), 32'(o_done), 32'(s >= last));
      checkOutput($sformatf("error s%0d", s), 32'(o_err), 32'd0);
      checkOutput($sformatf("reg_index s%0d", s), 32'(o_idx), 32'(expIdx));
      if (kCfg >= 0) begin
        checkOutput($sformatf("cfg_addr s%0d", s), 32'(o_addr), 32'(tblAddr[kCfg]));
        checkOutput($sformatf("cfg_data s%0d", s), 32'(o_data), 32'(tblData[kCfg]));
      end
      busyV = 1'b0;
      for (int k = 0; k < 3; k++)
        if (R[k] + d[k] <= s && s < R[k] + d[k] + L[k]) busyV = 1'b1;
      if (glitch && gap >= 2 && (s == F1[0] || s == F1[1])) busyV = 1'b1;
      if (s == last + 1) busyV = 1'b1;
      applyStimulus(busyV, (s == 10 && s < last - 1), (doAbort && s == abortAt));
    end
    if (aborted) begin
      // The frame already in the transmitter finishes while the DUT idles.
      for (int s = abortAt + 1; s < F1[1] + 2; s++) begin
        checkOutput($sformatf("post_reset_en s%0d", s), 32'({o_en, o_sb}), 32'd0);
        applyStimulus((s < R[1] + d[1] + L[1]), 1'b0, 1'b0);
      end
    end
  endtask

  // Linear directed sequence of scenarios.
  initial begin
    tx_busy = 1'b0; start_m = 1'b0; start_z = 1'b0; start_g = 1'b0; rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      sel = i;
      #0;
      checkAllZero($sformatf("reset_dut%0d", i));
    end
    sel = 0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkAllZero("idle_after_reset");

    $display("[TB] main instance: sequences from IDLE and DONE");
    runSequence(4, 1'b0);
    runSequence(4, 1'b0);
    $display("[TB] main instance: reset during XFER of entry 1");
    runSequence(4, 1'b1);
    runSequence(4, 1'b0);

    $display("[TB] empty table instance");
    sel = 1;
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("zero_done", 32'(o_done), 32'd1);
    checkOutput("zero_en_busy", 32'({o_en, o_sb}), 32'd0);
    for (int s = 0; s < 4; s++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("zero_hold s%0d", s), 32'({o_en, o_sb, o_done}), 32'b001);
    end

    $display("[TB] no-gap instance: start under busy, then sequences");
    sel = 2;
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("gap0_start_under_busy", 32'({o_en, o_sb, o_done}), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("gap0_still_idle", 32'({o_en, o_sb, o_done}), 32'd0);
    runSequence(0, 1'b0);
    runSequence(0, 1'b0);

`ifdef SPI_CFG_SEQ_TIMEOUT_EN
    $display("[TB] main instance: handshake timeout");
    sel = 0;
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int s = 0; s < 25; s++) begin
      checkOutput($sformatf("to_en s%0d", s), 32'(o_en), 32'(s < 20));
      checkOutput($sformatf("to_error s%0d", s), 32'(o_err), 32'(s >= 20));
      checkOutput($sformatf("to_busy s%0d", s), 32'(o_sb), 32'(s < 20));
      checkOutput($sformatf("to_idx s%0d", s), 32'(o_idx), 32'd0);
      applyStimulus(1'b0, (s == 24), 1'b0);
    end
    checkOutput("to_restart_error", 32'(o_err), 32'd0);
    checkOutput("to_restart_en", 32'(o_en), 32'd1);
    checkOutput("to_restart_addr", 32'(o_addr), 32'(tblAddr[0]));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
